// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle sequencer for an R/I-type RISC-V datapath. Every instruction is
// stepped through FETCH -> DECODE -> EXEC -> (MEM) -> WB. The controller
// drives all datapath enables and mux selects. It handshakes with variable
// latency instruction/data memories, counts retired instructions, and halts
// on an unsupported opcode.
//
// Optional feature macro:
//   STORE_SUPPORT_EN - when defined, opcode 0100011 (STORE) is legal and runs
//                      EXEC -> MEM (dmem_we=1) -> WB (pc_en only).
//                      When undefined, STORE is illegal and dmem_we is tied 0.
//
// Parameters:
//   CNT_W      width of the retired-instruction counter (wraps silently)
//
// Ports:
//   clk         in   system clock, all state changes on rising edge
//   rst         in   synchronous active-high reset; every output reads 0
//                    while it is high
//   inst        in   instruction word from imem, valid when imem_ready=1
//   imem_req    out  instruction fetch request (FETCH only)
//   imem_ready  in   imem delivers inst this cycle
//   dmem_req    out  data-memory request (MEM only)
//   dmem_we     out  data-memory write strobe (STORE in MEM only)
//   dmem_ready  in   dmem access completes this cycle
//   ir_en       out  load inst into the datapath IR (FETCH && imem_ready)
//   pc_en       out  advance PC (WB)
//   reg_we      out  register-file write enable (WB, not for STORE)
//   alu_src     out  ALU operand B: 0 = rs2, 1 = immediate
//   wb_sel      out  writeback source: 0 = ALU, 1 = dmem read data
//   alu_op      out  ALU operation code, stable from EXEC through WB
//   illegal     out  sticky unsupported-opcode flag
//   retired     out  retired-instruction count
//   state_dbg   out  current state encoding
//
// Handshake rule: a request (imem_req / dmem_req) is held high for as long
// as the controller sits in the request state; the transfer completes in the
// cycle where the matching ready input is high. Ready inputs are ignored in
// every other state, and the two requests are never high together.
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             ir_en,
  output logic             pc_en,
  output logic             reg_we,
  output logic             alu_src,
  output logic             wb_sel,
  output logic [3:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);

  // -------------------------------------------------------------------------
  // State encoding and opcode constants
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
`ifdef STORE_SUPPORT_EN
  localparam logic [6:0] OP_STORE = 7'b0100011;
`endif

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             f7b5_q, f7b5_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Only the opcode, funct3 and funct7[5] fields steer the controller; the
  // register and immediate fields belong to the datapath.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

  // -------------------------------------------------------------------------
  // Instruction class decode from the captured opcode
  // -------------------------------------------------------------------------
  logic is_r, is_i, is_load, is_store, is_legal, needs_mem;

  assign is_r    = (opcode_q == OP_R);
  assign is_i    = (opcode_q == OP_I);
  assign is_load = (opcode_q == OP_LOAD);
`ifdef STORE_SUPPORT_EN
  assign is_store = (opcode_q == OP_STORE);
`else
  assign is_store = 1'b0;
`endif
  assign is_legal  = is_r | is_i | is_load | is_store;
  assign needs_mem = is_load | is_store;

  // ALU operation from the captured fields. funct7[5] only matters for the
  // shift-right pair among immediates (srli/srai); for every other I-type
  // op that bit is part of the immediate and must not leak into alu_op.
  // Loads (and stores) always add to form the address.
  logic [3:0] alu_op_dec;

  always_comb begin
    alu_op_dec = 4'b0000;
    if (is_r) begin
      alu_op_dec = {f7b5_q, funct3_q};
    end else if (is_i) begin
      alu_op_dec = {(funct3_q == 3'b101) ? f7b5_q : 1'b0, funct3_q};
    end
  end

  // ir_en is the only strobe that looks at an input: the IR is loaded in the
  // exact cycle imem presents a valid word.
  logic ir_load;
  assign ir_load = (state_q == S_FETCH) && imem_ready;

  // -------------------------------------------------------------------------
  // Process 1: state and datapath-tracking registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opcode_q  <= 7'd0;
      funct3_q  <= 3'd0;
      f7b5_q    <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      f7b5_q    <= f7b5_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // -------------------------------------------------------------------------
  // Process 2: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    f7b5_d    = f7b5_q;
    illegal_d = illegal_q;
    retired_d = retired_q;

    if (ir_load) begin
      opcode_d = inst[6:0];
      funct3_d = inst[14:12];
      f7b5_d   = inst[30];
    end

    unique case (state_q)
      S_FETCH: begin
        if (imem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = needs_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_ready) state_d = S_WB;
      end
      S_WB: begin
        state_d   = S_FETCH;
        retired_d = retired_q + CNT_W'(1);
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      // Encodings 6 and 7 cannot be reached; fall back to a fresh fetch.
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Process 3: output decode (Moore on state + captured fields, except
  // ir_en). Everything is forced low while rst is high so the datapath sees
  // no strobe from an instruction that reset is aborting.
  // -------------------------------------------------------------------------
  logic       imem_req_c, dmem_req_c, dmem_we_c, ir_en_c, pc_en_c, reg_we_c;
  logic       alu_src_c, wb_sel_c;
  logic [3:0] alu_op_c;

  always_comb begin
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    ir_en_c    = 1'b0;
    pc_en_c    = 1'b0;
    reg_we_c   = 1'b0;
    alu_src_c  = 1'b0;
    wb_sel_c   = 1'b0;
    alu_op_c   = 4'b0000;

    unique case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        ir_en_c    = ir_load;
      end
      S_EXEC: begin
        alu_src_c = ~is_r;
        alu_op_c  = alu_op_dec;
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        alu_src_c  = 1'b1;
        alu_op_c   = alu_op_dec;
      end
      S_WB: begin
        pc_en_c   = 1'b1;
        reg_we_c  = ~is_store;
        wb_sel_c  = is_load;
        alu_src_c = ~is_r;
        alu_op_c  = alu_op_dec;
      end
      default: begin
        // DECODE, HALT and unreachable encodings drive nothing.
      end
    endcase
  end

  assign imem_req  = imem_req_c & ~rst;
  assign dmem_req  = dmem_req_c & ~rst;
`ifdef STORE_SUPPORT_EN
  assign dmem_we   = dmem_we_c & ~rst;
`else
  logic unused_dmem_we;
  assign unused_dmem_we = dmem_we_c;
  assign dmem_we   = 1'b0;
`endif
  assign ir_en     = ir_en_c & ~rst;
  assign pc_en     = pc_en_c & ~rst;
  assign reg_we    = reg_we_c & ~rst;
  assign alu_src   = alu_src_c & ~rst;
  assign wb_sel    = wb_sel_c & ~rst;
  assign alu_op    = rst ? 4'b0000 : alu_op_c;
  assign illegal   = illegal_q & ~rst;
  assign retired   = rst ? '0 : retired_q;
  assign state_dbg = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Table-driven bench for multicycle_ctrl (CNT_W = 4 so the wrap case is
// short). For each table record the expected per-cycle output pattern
// {mask, value} and the ready stimulus are pushed onto queues, then popped
// one cycle at a time: inputs are driven at the falling edge and outputs
// compared 1 ns later. Hand-written sequences cover reset during a MEM wait
// and counter wrap.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;
`ifdef STORE_SUPPORT_EN
  localparam bit STORE_LEGAL = 1'b1;
`else
  localparam bit STORE_LEGAL = 1'b0;
`endif

  // Observation word bit layout:
  // [15:13] state [12] imem_req [11] ir_en [10] dmem_req [9] dmem_we
  // [8] pc_en [7] reg_we [6] illegal [5] alu_src [4] wb_sel [3:0] alu_op
  localparam logic [15:0] M_CTRL = 16'hFFC0;
  localparam logic [15:0] M_SRC  = 16'h0020;
  localparam logic [15:0] M_WB   = 16'h0010;
  localparam logic [15:0] M_OP   = 16'h000F;
  localparam logic [15:0] M_ALL  = 16'hFFFF;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      inst = 32'd0;
  logic             imem_ready = 1'b0;
  logic             dmem_ready = 1'b0;
  logic             imem_req, dmem_req, dmem_we, ir_en, pc_en, reg_we;
  logic             alu_src, wb_sel, illegal;
  logic [3:0]       alu_op;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state_dbg;
  logic [15:0]      obs;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .ir_en      (ir_en),
    .pc_en      (pc_en),
    .reg_we     (reg_we),
    .alu_src    (alu_src),
    .wb_sel     (wb_sel),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .retired    (retired),
    .state_dbg  (state_dbg)
  );

  assign obs = {state_dbg, imem_req, ir_en, dmem_req, dmem_we, pc_en, reg_we,
                illegal, alu_src, wb_sel, alu_op};

  // ---------------- scoreboard state ----------------
  logic [31:0]      exp_q[$];   // {mask, masked expected observation}
  logic [1:0]       stim_q[$];  // {imem_ready, dmem_ready}
  logic [CNT_W-1:0] exp_ret = '0;
  int               n_vec  = 0;
  int               n_miss = 0;

  typedef struct {
    logic [31:0] inst;
    int          iwait;
    int          dwait;
    logic [3:0]  op;
    logic        src;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [15:0] pk(input logic [2:0] st, input logic ireq,
                                     input logic iren, input logic dreq,
                                     input logic dwe, input logic pce,
                                     input logic rwe, input logic ill,
                                     input logic src, input logic wbs,
                                     input logic [3:0] op);
    return {st, ireq, iren, dreq, dwe, pce, rwe, ill, src, wbs, op};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic cyc(input logic imr, input logic dmr,
                     input logic [15:0] m, input logic [15:0] v);
    @(negedge clk);
    imem_ready = imr;
    dmem_ready = dmr;
    #1;
    n_vec++;
    if (((obs & m) !== v) || (retired !== exp_ret)) begin
      n_miss++;
      $display("FAIL cycle t=%0t obs=%h exp=%h mask=%h retired=%0d exp_retired=%0d",
               $time, obs, v, m, retired, exp_ret);
    end
  endtask

  task automatic push(input logic [15:0] m, input logic [15:0] v,
                      input logic imr, input logic dmr);
    exp_q.push_back({m, v & m});
    stim_q.push_back({imr, dmr});
  endtask

  // Reset held for one cycle; every output must read 0 during it.
  task automatic do_reset(input logic dmr);
    @(negedge clk);
    rst = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = dmr;
    exp_ret = '0;
    #1;
    n_vec++;
    if ((obs !== 16'h0000) || (retired !== '0)) begin
      n_miss++;
      $display("FAIL reset_outputs obs=%h retired=%0d exp=0", obs, retired);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Expected sequence for one instruction, starting from FETCH.
  // cls: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 illegal
  task automatic run_instr(input vec_t r, output int cls);
    logic [31:0] e;
    logic [1:0]  s;
    logic [6:0]  opc;
    opc = r.inst[6:0];
    if (opc == 7'b0110011)                    cls = 0;
    else if (opc == 7'b0010011)               cls = 1;
    else if (opc == 7'b0000011)               cls = 2;
    else if (STORE_LEGAL && opc == 7'b0100011) cls = 3;
    else                                      cls = 4;
    inst = r.inst;

    for (int k = 0; k < r.iwait; k++)
      push(M_CTRL, pk(3'd0,1,0,0,0,0,0,0,0,0,4'd0), 1'b0, rb());
    push(M_CTRL, pk(3'd0,1,1,0,0,0,0,0,0,0,4'd0), 1'b1, rb());
    push(M_CTRL, pk(3'd1,0,0,0,0,0,0,0,0,0,4'd0), rb(), rb());
    if (cls == 4) begin
      // HALT cycle plus 10 more: nothing requested, illegal stays set.
      for (int k = 0; k < 11; k++)
        push(M_CTRL, pk(3'd5,0,0,0,0,0,0,1,0,0,4'd0), rb(), rb());
    end else begin
      push(M_CTRL | M_SRC | M_OP, pk(3'd2,0,0,0,0,0,0,0,r.src,0,r.op), rb(), rb());
      if (cls >= 2) begin
        for (int k = 0; k <= r.dwait; k++)
          push(M_CTRL | M_SRC | M_OP,
               pk(3'd3,0,0,1,(cls == 3),0,0,0,1,0,r.op), rb(), (k == r.dwait));
      end
      push(M_CTRL | M_WB | M_OP,
           pk(3'd4,0,0,0,0,1,(cls != 3),0,0,(cls == 2),r.op), rb(), rb());
    end

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      cyc(s[1], s[0], e[31:16], e[15:0]);
      if (e[15:13] == 3'd4) exp_ret++;   // retired bumps on the WB edge
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int   cls;
    vec_t w;

    //          inst          iwait dwait op       src
    tbl[0]  = '{32'h002081B3, 0, 0, 4'b0000, 1'b0};  // add
    tbl[1]  = '{32'h402081B3, 1, 0, 4'b1000, 1'b0};  // sub, one imem wait
    tbl[2]  = '{32'h4030D193, 0, 0, 4'b1101, 1'b1};  // srai
    tbl[3]  = '{32'h00308193, 2, 0, 4'b0000, 1'b1};  // addi, two imem waits
    tbl[4]  = '{32'h40308193, 0, 0, 4'b0000, 1'b1};  // addi, imm bit30 set
    tbl[5]  = '{32'h0020F1B3, 0, 0, 4'b0111, 1'b0};  // and
    tbl[6]  = '{32'h4020D1B3, 0, 0, 4'b1101, 1'b0};  // sra
    tbl[7]  = '{32'h0000A183, 0, 3, 4'b0000, 1'b0};  // lw, 3 dmem waits
    tbl[8]  = '{32'h0000A183, 1, 0, 4'b0000, 1'b0};  // lw, zero dmem wait
    tbl[9]  = '{32'h0030A023, 0, 1, 4'b0000, 1'b1};  // sw
    tbl[10] = '{32'h0000006F, 0, 0, 4'b0000, 1'b0};  // jal: unsupported
    tbl[7].src = 1'b1;
    tbl[8].src = 1'b1;

    do_reset(1'b0);

    for (int i = 0; i < 11; i++) begin
      run_instr(tbl[i], cls);
      if (cls == 4) do_reset(1'b0);
    end

    // Reset while a load waits in MEM: no WB strobes, fresh FETCH, count 0.
    run_instr(tbl[0], cls);
    run_instr(tbl[2], cls);
    inst = 32'h0000A183;
    cyc(1'b1, 1'b0, M_CTRL, pk(3'd0,1,1,0,0,0,0,0,0,0,4'd0));
    cyc(1'b0, 1'b1, M_CTRL, pk(3'd1,0,0,0,0,0,0,0,0,0,4'd0));
    cyc(1'b1, 1'b1, M_CTRL | M_SRC, pk(3'd2,0,0,0,0,0,0,0,1,0,4'd0));
    cyc(1'b1, 1'b0, M_CTRL | M_SRC, pk(3'd3,0,0,1,0,0,0,0,1,0,4'd0));
    cyc(1'b1, 1'b0, M_CTRL | M_SRC, pk(3'd3,0,0,1,0,0,0,0,1,0,4'd0));
    do_reset(1'b1);
    cyc(1'b0, 1'b0, M_CTRL, pk(3'd0,1,0,0,0,0,0,0,0,0,4'd0));

    // Counter wrap: 16 retirements on a 4-bit counter land back on 0.
    for (int i = 0; i < 16; i++) begin
      w = tbl[0];
      w.iwait = $urandom_range(0, 2);
      run_instr(w, cls);
    end
    cyc(1'b0, 1'b0, M_CTRL, pk(3'd0,1,0,0,0,0,0,0,0,0,4'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
